// File: rtl/decode_stage_if.sv
// Interface bundling the decode stage's upstream/downstream handshakes, flush and decoded outputs.
//   master : upstream/downstream side; drives flush, in_valid, in_instr, out_ready
//   slave  : decode stage; drives in_ready, out_valid and every decoded field
interface decode_stage_if #(
  parameter int unsigned INSTR_W    = 16,
  parameter int unsigned OPC_W      = 3,
  parameter int unsigned REG_ADDR_W = 3,
  parameter int unsigned IMM_W      = 8,
  parameter int unsigned CNT_W      = 8
);
  logic                  flush;
  logic                  in_valid;
  logic [INSTR_W-1:0]    in_instr;
  logic                  in_ready;
  logic                  out_valid;
  logic                  out_ready;
  logic [OPC_W-1:0]      alu_op;
  logic                  reg_write_enable;
  logic [REG_ADDR_W-1:0] dest_reg_sel;
  logic [REG_ADDR_W-1:0] src_reg1_sel;
  logic [REG_ADDR_W-1:0] src_reg2_sel;
  logic                  load_immediate;
  logic [IMM_W-1:0]      immediate_data;
  logic                  illegal;
  logic [CNT_W-1:0]      illegal_count;
  logic                  raw_hazard;

  modport master (
    output flush, in_valid, in_instr, out_ready,
    input  in_ready, out_valid, alu_op, reg_write_enable, dest_reg_sel, src_reg1_sel,
           src_reg2_sel, load_immediate, immediate_data, illegal, illegal_count, raw_hazard
  );

  modport slave (
    input  flush, in_valid, in_instr, out_ready,
    output in_ready, out_valid, alu_op, reg_write_enable, dest_reg_sel, src_reg1_sel,
           src_reg2_sel, load_immediate, immediate_data, illegal, illegal_count, raw_hazard
  );
endinterface

// File: rtl/decode_stage.sv
// Registered instruction decode stage with valid/ready handshake on both sides.
// Decodes one instruction per cycle into ALU/register-file controls, holds the result in an
// output pipeline register, supports a synchronous flush and counts accepted illegal opcodes
// (saturating).
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : decode_stage_if.slave (flush, in_valid/in_instr/in_ready, out_valid/out_ready,
//          decoded fields, illegal, illegal_count, raw_hazard)
// Optional feature: define DECODE_HAZARD_EN to track the last written destination and flag
// read-after-write hazards on raw_hazard; otherwise raw_hazard is tied low.
module decode_stage #(
  parameter int unsigned INSTR_W    = 16,
  parameter int unsigned OPC_W      = 3,
  parameter int unsigned REG_ADDR_W = 3,
  parameter int unsigned IMM_W      = 8,
  parameter int unsigned CNT_W      = 8
) (
  input  logic           clk,
  input  logic           rst,
  decode_stage_if.slave  bus
);

  if (OPC_W + 3 * REG_ADDR_W > INSTR_W) begin : g_bad_reg_fields
    $error("decode_stage: OPC_W + 3*REG_ADDR_W exceeds INSTR_W");
  end
  if (OPC_W + REG_ADDR_W + IMM_W > INSTR_W) begin : g_bad_imm_field
    $error("decode_stage: OPC_W + REG_ADDR_W + IMM_W exceeds INSTR_W");
  end

  localparam logic [OPC_W-1:0] OpAdd = OPC_W'(0);
  localparam logic [OPC_W-1:0] OpSub = OPC_W'(1);
  localparam logic [OPC_W-1:0] OpAnd = OPC_W'(2);
  localparam logic [OPC_W-1:0] OpOr  = OPC_W'(3);
  localparam logic [OPC_W-1:0] OpNot = OPC_W'(4);
  localparam logic [OPC_W-1:0] OpLdi = OPC_W'(5);

  // Instruction fields, MSB down; the immediate overlaps the source fields.
  logic [OPC_W-1:0]      f_opc;
  logic [REG_ADDR_W-1:0] f_dest;
  logic [REG_ADDR_W-1:0] f_src1;
  logic [REG_ADDR_W-1:0] f_src2;
  logic [IMM_W-1:0]      f_imm;

  assign f_opc  = bus.in_instr[INSTR_W-1 -: OPC_W];
  assign f_dest = bus.in_instr[INSTR_W-OPC_W-1 -: REG_ADDR_W];
  assign f_src1 = bus.in_instr[INSTR_W-OPC_W-REG_ADDR_W-1 -: REG_ADDR_W];
  assign f_src2 = bus.in_instr[INSTR_W-OPC_W-2*REG_ADDR_W-1 -: REG_ADDR_W];
  assign f_imm  = bus.in_instr[IMM_W-1:0];

  // Combinational decode of the presented instruction
  logic [OPC_W-1:0]      dec_alu_op;
  logic                  dec_we;
  logic [REG_ADDR_W-1:0] dec_dest;
  logic [REG_ADDR_W-1:0] dec_src1;
  logic [REG_ADDR_W-1:0] dec_src2;
  logic                  dec_ldi;
  logic [IMM_W-1:0]      dec_imm;
  logic                  dec_illegal;
  logic                  dec_hazard;

  always_comb begin
    dec_alu_op  = '0;
    dec_we      = 1'b0;
    dec_dest    = '0;
    dec_src1    = '0;
    dec_src2    = '0;
    dec_ldi     = 1'b0;
    dec_imm     = '0;
    dec_illegal = 1'b0;
    case (f_opc)
      OpAdd, OpSub, OpAnd, OpOr: begin
        dec_alu_op = f_opc;
        dec_we     = 1'b1;
        dec_dest   = f_dest;
        dec_src1   = f_src1;
        dec_src2   = f_src2;
      end
      OpNot: begin
        dec_alu_op = f_opc;
        dec_we     = 1'b1;
        dec_dest   = f_dest;
        dec_src1   = f_src1;
      end
      OpLdi: begin
        dec_we   = 1'b1;
        dec_ldi  = 1'b1;
        dec_dest = f_dest;
        dec_imm  = f_imm;
      end
      default: dec_illegal = 1'b1;
    endcase
  end

  // Handshake
  logic out_valid_q;
  logic accept;

  assign bus.in_ready = !out_valid_q || bus.out_ready;
  assign accept       = bus.in_valid && bus.in_ready && !bus.flush;

  // Output pipeline register and illegal counter
  logic [OPC_W-1:0]      alu_op_q;
  logic                  we_q;
  logic [REG_ADDR_W-1:0] dest_q;
  logic [REG_ADDR_W-1:0] src1_q;
  logic [REG_ADDR_W-1:0] src2_q;
  logic                  ldi_q;
  logic [IMM_W-1:0]      imm_q;
  logic                  illegal_q;
  logic                  hazard_q;
  logic [CNT_W-1:0]      cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      alu_op_q    <= '0;
      we_q        <= 1'b0;
      dest_q      <= '0;
      src1_q      <= '0;
      src2_q      <= '0;
      ldi_q       <= 1'b0;
      imm_q       <= '0;
      illegal_q   <= 1'b0;
      hazard_q    <= 1'b0;
      cnt_q       <= '0;
    end else if (bus.flush) begin
      // Flush drops both the held beat and any beat presented this cycle
      out_valid_q <= 1'b0;
      alu_op_q    <= '0;
      we_q        <= 1'b0;
      dest_q      <= '0;
      src1_q      <= '0;
      src2_q      <= '0;
      ldi_q       <= 1'b0;
      imm_q       <= '0;
      illegal_q   <= 1'b0;
      hazard_q    <= 1'b0;
    end else if (accept) begin
      out_valid_q <= 1'b1;
      alu_op_q    <= dec_alu_op;
      we_q        <= dec_we;
      dest_q      <= dec_dest;
      src1_q      <= dec_src1;
      src2_q      <= dec_src2;
      ldi_q       <= dec_ldi;
      imm_q       <= dec_imm;
      illegal_q   <= dec_illegal;
      hazard_q    <= dec_hazard;
      if (dec_illegal && (cnt_q != {CNT_W{1'b1}})) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

`ifdef DECODE_HAZARD_EN
  logic [REG_ADDR_W-1:0] last_dest_q;
  logic                  last_dest_valid_q;
  logic                  rd_src1;
  logic                  rd_src2;

  assign rd_src1 = (f_opc == OpAdd) || (f_opc == OpSub) || (f_opc == OpAnd) ||
                   (f_opc == OpOr)  || (f_opc == OpNot);
  assign rd_src2 = (f_opc == OpAdd) || (f_opc == OpSub) || (f_opc == OpAnd) ||
                   (f_opc == OpOr);

  assign dec_hazard = last_dest_valid_q &&
                      ((rd_src1 && (f_src1 == last_dest_q)) ||
                       (rd_src2 && (f_src2 == last_dest_q)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_dest_q       <= '0;
      last_dest_valid_q <= 1'b0;
    end else if (bus.flush) begin
      last_dest_valid_q <= 1'b0;
    end else if (accept) begin
      // A non-writing beat breaks the dependency chain
      last_dest_valid_q <= dec_we;
      if (dec_we) begin
        last_dest_q <= dec_dest;
      end
    end
  end
`else
  assign dec_hazard = 1'b0;
`endif

  assign bus.out_valid        = out_valid_q;
  assign bus.alu_op           = alu_op_q;
  assign bus.reg_write_enable = we_q;
  assign bus.dest_reg_sel     = dest_q;
  assign bus.src_reg1_sel     = src1_q;
  assign bus.src_reg2_sel     = src2_q;
  assign bus.load_immediate   = ldi_q;
  assign bus.immediate_data   = imm_q;
  assign bus.illegal          = illegal_q;
  assign bus.illegal_count    = cnt_q;
  assign bus.raw_hazard       = hazard_q;

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking directed testbench for decode_stage.
module tb_decode_stage;
  localparam int unsigned INSTR_W    = 16;
  localparam int unsigned OPC_W      = 3;
  localparam int unsigned REG_ADDR_W = 3;
  localparam int unsigned IMM_W      = 8;
  localparam int unsigned CNT_W      = 8;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   fails  = 0;

  always #5 clk = ~clk;

  decode_stage_if #(
    .INSTR_W(INSTR_W), .OPC_W(OPC_W), .REG_ADDR_W(REG_ADDR_W), .IMM_W(IMM_W), .CNT_W(CNT_W)
  ) bus ();

  decode_stage #(
    .INSTR_W(INSTR_W), .OPC_W(OPC_W), .REG_ADDR_W(REG_ADDR_W), .IMM_W(IMM_W), .CNT_W(CNT_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // {valid, alu_op, we, dest, src1, src2, ldi, imm, illegal}
  logic [23:0] obs;
  assign obs = {bus.out_valid, bus.alu_op, bus.reg_write_enable, bus.dest_reg_sel,
                bus.src_reg1_sel, bus.src_reg2_sel, bus.load_immediate, bus.immediate_data,
                bus.illegal};

  function automatic logic [23:0] beat(input logic v, input logic [2:0] op, input logic we,
                                       input logic [2:0] d, input logic [2:0] s1,
                                       input logic [2:0] s2, input logic ldi,
                                       input logic [7:0] imm, input logic ill);
    return {v, op, we, d, s1, s2, ldi, imm, ill};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    #3;
    rst = 1'b0;
    step();
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if (obs !== 24'h0 || bus.illegal_count !== 8'h00 || bus.raw_hazard !== 1'b0) begin
      $display("FAIL reset_outputs: got %h cnt %h hz %b, want 000000 cnt 00 hz 0",
               obs, bus.illegal_count, bus.raw_hazard);
      fails++;
    end
    step();
    rst = 1'b0;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      $display("FAIL reset_in_ready: got %b want 1", bus.in_ready);
      fails++;
    end
  endtask

  task automatic test_add();
    logic [23:0] exp;
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_instr  = 16'h1510;
    step();
    bus.in_valid = 1'b0;
    exp = beat(1, 3'd0, 1, 3'd5, 3'd2, 3'd1, 0, 8'h00, 0);
    checks++;
    if (obs !== exp) begin
      $display("FAIL add_beat: got %h want %h", obs, exp);
      fails++;
    end
    step();
    checks++;
    if (bus.out_valid !== 1'b0) begin
      $display("FAIL add_drain: out_valid got %b want 0", bus.out_valid);
      fails++;
    end
  endtask

  task automatic test_back_to_back();
    logic [23:0] exp;
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_instr  = 16'hBC7F;
    step();
    exp = beat(1, 3'd0, 1, 3'd7, 3'd0, 3'd0, 1, 8'h7F, 0);
    checks++;
    if (obs !== exp) begin
      $display("FAIL b2b_ldi: got %h want %h", obs, exp);
      fails++;
    end
    bus.in_instr = 16'h8500;
    step();
    bus.in_valid = 1'b0;
    exp = beat(1, 3'd4, 1, 3'd1, 3'd2, 3'd0, 0, 8'h00, 0);
    checks++;
    if (obs !== exp) begin
      $display("FAIL b2b_not: got %h want %h", obs, exp);
      fails++;
    end
    step();
    checks++;
    if (bus.out_valid !== 1'b0) begin
      $display("FAIL b2b_drain: out_valid got %b want 0", bus.out_valid);
      fails++;
    end
  endtask

  task automatic test_illegal_saturate();
    logic [23:0] exp;
    logic [7:0]  exp_cnt;
    exp = beat(1, 3'd0, 0, 3'd0, 3'd0, 3'd0, 0, 8'h00, 1);
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_instr  = 16'hC000;
    for (int i = 0; i < 300; i++) begin
      step();
      exp_cnt = (i + 1 > 255) ? 8'hFF : 8'(i + 1);
      checks++;
      if (obs !== exp || bus.illegal_count !== exp_cnt) begin
        $display("FAIL illegal_beat_%0d: got %h cnt %h want %h cnt %h",
                 i, obs, bus.illegal_count, exp, exp_cnt);
        fails++;
      end
    end
    bus.in_valid = 1'b0;
    step();
    checks++;
    if (bus.out_valid !== 1'b0 || bus.illegal_count !== 8'hFF) begin
      $display("FAIL illegal_final: valid %b cnt %h want 0 ff", bus.out_valid, bus.illegal_count);
      fails++;
    end
  endtask

  task automatic test_backpressure();
    logic [23:0] exp;
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_instr  = 16'h1510;
    step();
    bus.in_instr = 16'hBC7F;
    exp = beat(1, 3'd0, 1, 3'd5, 3'd2, 3'd1, 0, 8'h00, 0);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (obs !== exp || bus.in_ready !== 1'b0) begin
        $display("FAIL stall_%0d: got %h rdy %b want %h rdy 0", i, obs, bus.in_ready, exp);
        fails++;
      end
      step();
    end
    bus.out_ready = 1'b1;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      $display("FAIL release_ready: got %b want 1", bus.in_ready);
      fails++;
    end
    step();
    bus.in_valid = 1'b0;
    exp = beat(1, 3'd0, 1, 3'd7, 3'd0, 3'd0, 1, 8'h7F, 0);
    checks++;
    if (obs !== exp) begin
      $display("FAIL release_next: got %h want %h", obs, exp);
      fails++;
    end
    step();
  endtask

  task automatic test_flush();
    pulse_reset();
    bus.out_ready = 1'b1;
    bus.flush     = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_instr  = 16'hC000;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      $display("FAIL flush_in_ready: got %b want 1", bus.in_ready);
      fails++;
    end
    step();
    checks++;
    if (obs !== 24'h0 || bus.illegal_count !== 8'h00) begin
      $display("FAIL flush_drop: got %h cnt %h want 000000 cnt 00", obs, bus.illegal_count);
      fails++;
    end
    // Flush a held, stalled beat
    bus.flush     = 1'b0;
    bus.out_ready = 1'b0;
    bus.in_instr  = 16'h1510;
    step();
    bus.in_valid = 1'b0;
    bus.flush    = 1'b1;
    step();
    bus.flush = 1'b0;
    checks++;
    if (obs !== 24'h0) begin
      $display("FAIL flush_held: got %h want 000000", obs);
      fails++;
    end
  endtask

  task automatic test_reset_mid_stall();
    logic [23:0] exp;
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_instr  = 16'hC000;
    step();
    bus.in_valid = 1'b0;
    exp = beat(1, 3'd0, 0, 3'd0, 3'd0, 3'd0, 0, 8'h00, 1);
    step();
    checks++;
    if (obs !== exp || bus.illegal_count !== 8'h01) begin
      $display("FAIL pre_reset_stall: got %h cnt %h want %h cnt 01", obs, bus.illegal_count, exp);
      fails++;
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (obs !== 24'h0 || bus.illegal_count !== 8'h00) begin
      $display("FAIL async_reset: got %h cnt %h want 000000 cnt 00", obs, bus.illegal_count);
      fails++;
    end
    rst = 1'b0;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      $display("FAIL post_reset_ready: got %b want 1", bus.in_ready);
      fails++;
    end
    step();
  endtask

  task automatic test_hazard();
    logic exp_hz;
`ifdef DECODE_HAZARD_EN
    exp_hz = 1'b1;
`else
    exp_hz = 1'b0;
`endif
    pulse_reset();
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_instr  = 16'h1510;
    step();
    checks++;
    if (bus.raw_hazard !== 1'b0) begin
      $display("FAIL hazard_first: got %b want 0", bus.raw_hazard);
      fails++;
    end
    bus.in_instr = 16'h2EA0;
    step();
    bus.in_valid = 1'b0;
    checks++;
    if (bus.raw_hazard !== exp_hz || bus.src_reg1_sel !== 3'd5) begin
      $display("FAIL hazard_pair: got hz %b src1 %0d want hz %b src1 5",
               bus.raw_hazard, bus.src_reg1_sel, exp_hz);
      fails++;
    end
    // Same pair with a flush between them
    bus.in_valid = 1'b1;
    bus.in_instr = 16'h1510;
    step();
    bus.in_valid = 1'b0;
    bus.flush    = 1'b1;
    step();
    bus.flush    = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_instr = 16'h2EA0;
    step();
    bus.in_valid = 1'b0;
    checks++;
    if (bus.raw_hazard !== 1'b0 || bus.out_valid !== 1'b1) begin
      $display("FAIL hazard_flushed: got hz %b valid %b want hz 0 valid 1",
               bus.raw_hazard, bus.out_valid);
      fails++;
    end
    step();
  endtask

  initial begin
    rst           = 1'b1;
    bus.flush     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_instr  = '0;
    bus.out_ready = 1'b0;
    test_reset();
    test_add();
    test_back_to_back();
    test_illegal_saturate();
    test_backpressure();
    test_flush();
    test_reset_mid_stall();
    test_hazard();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
